smash_out_arbiter: RTL and testbench



---
 rtl/smash_pkg.sv | 23 ++
 rtl/smash_rr_arbiter.sv | 30 +++
 rtl/smash_out_arbiter.sv | 120 ++++++++++++
 tb/tb_smash_out_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smash_pkg.sv
// Flit encoding shared by smash_fifo users, the NI and the router output stage.
package smash_pkg;

  localparam int FLIT_TYPE_W = 2;

  typedef enum logic [FLIT_TYPE_W-1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_HEAD   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  // Callers pass data[DATA_SIZE-1 -: FLIT_TYPE_W]; this keeps the helper width-independent.
  function automatic flit_t flit_type(input logic [FLIT_TYPE_W-1:0] type_bits);
    return flit_t'(type_bits);
  endfunction

endpackage

// File: rtl/smash_rr_arbiter.sv
// Combinational rotate-priority pick: first request after last_i, wrapping modulo N.
module smash_rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = last_i;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(last_i) + i) % N);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/smash_out_arbiter.sv
// Router output stage: round-robin wormhole arbitration over FWFT FIFOs into a
// one-flit registered valid/ready output link.
module smash_out_arbiter
  import smash_pkg::*;
#(
  parameter int NUM_IN    = 4,
  parameter int DATA_SIZE = 32,
  localparam int IDX_W    = $clog2(NUM_IN)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_IN*DATA_SIZE-1:0] i_fifo_data,
  input  logic [NUM_IN-1:0]         i_fifo_empty,
  output logic [NUM_IN-1:0]         o_fifo_read,
  output logic [DATA_SIZE-1:0]      o_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_err,
  output logic [IDX_W-1:0]          o_grant,
  output logic                      o_locked
);

  arb_state_t           state_q, state_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic                 valid_q, valid_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic                 err_q, err_d;

  logic [DATA_SIZE-1:0] front [NUM_IN];
  flit_t                front_type [NUM_IN];
  logic [NUM_IN-1:0]    start_req, orphan, orphan_low;
  logic [NUM_IN-1:0]    rr_gnt;
  logic [IDX_W-1:0]     rr_idx;
  logic                 load;
  flit_t                sel_type;

  always_comb begin
    for (int k = 0; k < NUM_IN; k++) begin
      front[k]      = i_fifo_data[k*DATA_SIZE +: DATA_SIZE];
      front_type[k] = flit_type(front[k][DATA_SIZE-1 -: FLIT_TYPE_W]);
      start_req[k]  = !i_fifo_empty[k] &&
                      (front_type[k] == FLIT_HEAD || front_type[k] == FLIT_SINGLE);
      orphan[k]     = !i_fifo_empty[k] &&
                      (front_type[k] == FLIT_BODY || front_type[k] == FLIT_TAIL);
    end
  end

  // Isolate the lowest set bit so only one orphan is discarded per cycle.
  assign orphan_low = orphan & (~orphan + {{(NUM_IN-1){1'b0}}, 1'b1});
  assign load       = !valid_q || i_ready;

  smash_rr_arbiter #(.N(NUM_IN)) u_rr (
    .req_i  (start_req),
    .last_i (grant_q),
    .gnt_o  (rr_gnt),
    .idx_o  (rr_idx)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    valid_d     = valid_q && !i_ready;
    data_d      = data_q;
    err_d       = 1'b0;
    o_fifo_read = '0;
    sel_type    = FLIT_BODY;
    case (state_q)
      ST_IDLE: begin
        sel_type = front_type[rr_idx];
        if (|start_req) begin
          if (load) begin
            o_fifo_read = rr_gnt;
            data_d      = front[rr_idx];
            valid_d     = 1'b1;
            grant_d     = rr_idx;
            if (sel_type == FLIT_HEAD) state_d = ST_LOCKED;
          end
        end else if (|orphan) begin
          o_fifo_read = orphan_low;
          err_d       = 1'b1;
        end
      end
      ST_LOCKED: begin
        sel_type = front_type[grant_q];
        if (load && !i_fifo_empty[grant_q]) begin
          o_fifo_read[grant_q] = 1'b1;
          data_d               = front[grant_q];
          valid_d              = 1'b1;
          if (sel_type == FLIT_TAIL) state_d = ST_IDLE;
          if (sel_type == FLIT_HEAD || sel_type == FLIT_SINGLE) err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (i_rst) o_fifo_read = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      grant_q <= IDX_W'(NUM_IN - 1);
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign o_data   = data_q;
  assign o_valid  = valid_q;
  assign o_err    = err_q;
  assign o_grant  = grant_q;
  assign o_locked = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_smash_out_arbiter.sv
// Bench for smash_out_arbiter: emulated FWFT FIFOs, queue-based reference model,
// scoreboard of expected output flits checked by an independent monitor.
module tb_smash_out_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] fifo_data;
  logic [N-1:0]   fifo_empty;
  logic [N-1:0]   fifo_read;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           ready;
  logic           err;
  logic [1:0]     grant;
  logic           locked;

  smash_out_arbiter #(.NUM_IN(N), .DATA_SIZE(W)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_fifo_data  (fifo_data),
    .i_fifo_empty (fifo_empty),
    .o_fifo_read  (fifo_read),
    .o_data       (out_data),
    .o_valid      (out_valid),
    .i_ready      (ready),
    .o_err        (err),
    .o_grant      (grant),
    .o_locked     (locked)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  logic [W-1:0] fifo_q [N][$];
  logic [W-1:0] src_q  [N][$];
  logic [W-1:0] exp_q  [$];

  int n_checks = 0;
  int n_fail   = 0;
  int err_seen = 0;
  bit chk_en   = 1'b0;
  bit drip     = 1'b0;

  // model: cur_* is what the DUT should show this cycle, nxt_* after the next edge
  logic       cur_valid, cur_err, cur_locked;
  logic [1:0] cur_grant;
  logic       nxt_valid, nxt_err, nxt_locked;
  logic [1:0] nxt_grant;
  logic [N-1:0] exp_read;
  int           pop_idx;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ftype(input logic [W-1:0] f);
    return f[W-1 -: 2];
  endfunction

  task automatic drive_fronts();
    logic [W-1:0] f;
    for (int k = 0; k < N; k++) begin
      fifo_empty[k] = (fifo_q[k].size() == 0);
      f = (fifo_q[k].size() > 0) ? fifo_q[k][0] : 32'h0;
      fifo_data[k*W +: W] = f;
    end
  endtask

  task automatic take(input int k);
    pop_idx     = k;
    exp_read[k] = 1'b1;
    exp_q.push_back(fifo_q[k][0]);
    nxt_valid   = 1'b1;
  endtask

  // Reference rules evaluated on the queue contents visible this cycle.
  task automatic model_eval();
    bit  load;
    int  win, k;
    logic [W-1:0] f;
    exp_read = '0;
    pop_idx  = -1;
    if (rst) begin
      nxt_valid = 0; nxt_err = 0; nxt_locked = 0; nxt_grant = 2'(N - 1);
      exp_q.delete();
      return;
    end
    load       = !cur_valid || ready;
    nxt_valid  = cur_valid && !ready;
    nxt_err    = 0;
    nxt_locked = cur_locked;
    nxt_grant  = cur_grant;
    if (!cur_locked) begin
      win = -1;
      for (int i = 1; i <= N; i++) begin
        k = (int'(cur_grant) + i) % N;
        if (win < 0 && fifo_q[k].size() > 0) begin
          f = fifo_q[k][0];
          if (ftype(f) == 2'b01 || ftype(f) == 2'b11) win = k;
        end
      end
      if (win >= 0) begin
        if (load) begin
          f = fifo_q[win][0];
          take(win);
          nxt_grant  = 2'(win);
          nxt_locked = (ftype(f) == 2'b01);
        end
      end else begin
        for (int j = N - 1; j >= 0; j--)
          if (fifo_q[j].size() > 0) win = j;
        if (win >= 0) begin
          pop_idx       = win;
          exp_read[win] = 1'b1;
          nxt_err       = 1'b1;
        end
      end
    end else if (load && fifo_q[cur_grant].size() > 0) begin
      f = fifo_q[cur_grant][0];
      take(int'(cur_grant));
      if (ftype(f) == 2'b10) nxt_locked = 0;
      if (ftype(f) == 2'b01 || ftype(f) == 2'b11) nxt_err = 1'b1;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit rd);
    @(posedge clk);
    #1;
    cur_valid  = nxt_valid;
    cur_err    = nxt_err;
    cur_locked = nxt_locked;
    cur_grant  = nxt_grant;
    if (pop_idx >= 0) void'(fifo_q[pop_idx].pop_front());
    if (drip)
      for (int k = 0; k < N; k++)
        if (src_q[k].size() > 0 && $urandom_range(0, 1) == 1)
          fifo_q[k].push_back(src_q[k].pop_front());
    rst   = r;
    ready = rd;
    drive_fronts();
    model_eval();
  endtask

  function automatic logic [W-1:0] mk(input logic [1:0] t, input int k);
    logic [W-1:0] v;
    v = {t, 2'(k), 28'($urandom)};
    return v;
  endfunction

  task automatic gen_packet(input int k);
    int r, nb;
    r = $urandom_range(0, 19);
    if (r < 2) begin
      src_q[k].push_back(mk((r == 0) ? 2'b00 : 2'b10, k));
    end else if (r < 5) begin
      src_q[k].push_back(mk(2'b11, k));
    end else if (r == 5) begin
      src_q[k].push_back(mk(2'b01, k));
      src_q[k].push_back(mk(2'b01, k));
      src_q[k].push_back(mk(2'b10, k));
    end else begin
      nb = $urandom_range(0, 3);
      src_q[k].push_back(mk(2'b01, k));
      for (int b = 0; b < nb; b++) src_q[k].push_back(mk(2'b00, k));
      src_q[k].push_back(mk(2'b10, k));
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic         prev_valid = 1'b0, prev_ready = 1'b0, prev_rst = 1'b1;
  logic [W-1:0] prev_data  = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("fifo_read", 32'(fifo_read), 32'(exp_read));
      check("valid",     32'(out_valid), 32'(cur_valid));
      check("err",       32'(err),       32'(cur_err));
      check("grant",     32'(grant),     32'(cur_grant));
      check("locked",    32'(locked),    32'(cur_locked));
      if (prev_valid && !prev_ready && !prev_rst) begin
        check("hold_valid", 32'(out_valid), 32'h1);
        check("hold_data",  out_data,       prev_data);
      end
      if (out_valid && ready && !rst) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL data_unexpected: got %h expected none at %0t", out_data, $time);
        end else begin
          check("data", out_data, exp_q.pop_front());
        end
      end
      if (err) err_seen++;
    end
    prev_valid = out_valid;
    prev_ready = ready;
    prev_rst   = rst;
    prev_data  = out_data;
  end

  // ---------------- stimulus ----------------
  int e0, cyc;
  bit busy;

  initial begin
    rst = 1'b1; ready = 1'b0; fifo_data = '0; fifo_empty = '1;
    nxt_valid = 0; nxt_err = 0; nxt_locked = 0; nxt_grant = 2'(N - 1);
    exp_read = '0; pop_idx = -1;
    step(1, 0);
    chk_en = 1'b1;
    step(1, 0);

    // single packet, no contention
    fifo_q[0].push_back(32'hC000_0001);
    repeat (4) step(0, 1);

    // round-robin fairness from reset
    step(1, 0);
    for (int k = 0; k < N; k++) fifo_q[k].push_back(32'hC000_0100 + 32'(k));
    fifo_q[0].push_back(32'hC000_0200);
    repeat (8) step(0, 1);

    // wormhole lock with a competing single
    fifo_q[1].push_back(32'h4000_0011);
    fifo_q[1].push_back(32'h0000_0012);
    fifo_q[1].push_back(32'h8000_0013);
    fifo_q[2].push_back(32'hC000_0021);
    repeat (8) step(0, 1);

    // backpressure mid-packet
    fifo_q[1].push_back(32'h4000_0111);
    for (int b = 0; b < 3; b++) fifo_q[1].push_back(32'h0000_0112 + 32'(b));
    fifo_q[1].push_back(32'h8000_0115);
    step(0, 1); step(0, 1);
    repeat (3) step(0, 0);
    repeat (8) step(0, 1);

    // orphan discard while idle
    @(negedge clk); #1;
    e0 = err_seen;
    fifo_q[3].push_back(32'h0000_0033);
    repeat (4) step(0, 1);
    @(negedge clk); #1;
    check("orphan_err_pulses", 32'(err_seen - e0), 32'd1);

    // protocol error: second HEAD while locked
    fifo_q[0].push_back(32'h4000_0a01);
    fifo_q[0].push_back(32'h4000_0a02);
    fifo_q[0].push_back(32'h8000_0a03);
    repeat (6) step(0, 1);

    // reset during the body of a 4-flit packet
    fifo_q[0].push_back(32'h4000_0b01);
    fifo_q[0].push_back(32'h0000_0b02);
    fifo_q[0].push_back(32'h0000_0b03);
    fifo_q[0].push_back(32'h8000_0b04);
    step(0, 1); step(0, 1);
    @(negedge clk); #1;
    e0 = err_seen;
    step(1, 0);
    repeat (6) step(0, 1);
    @(negedge clk); #1;
    check("reset_orphan_err_pulses", 32'(err_seen - e0), 32'd2);
    check("reset_fifo0_drained", 32'(fifo_q[0].size()), 32'd0);

    // randomized traffic with trickling arrivals and random backpressure
    for (int k = 0; k < N; k++)
      for (int p = 0; p < 10; p++) gen_packet(k);
    drip = 1'b1;
    cyc  = 0;
    busy = 1'b1;
    while (busy && cyc < 4000) begin
      step(0, $urandom_range(0, 3) != 0);
      cyc++;
      busy = (exp_q.size() > 0) || cur_valid;
      for (int k = 0; k < N; k++)
        if (src_q[k].size() > 0 || fifo_q[k].size() > 0) busy = 1'b1;
    end
    check("random_drain_in_budget", 32'(busy), 32'd0);
    repeat (3) step(0, 1);
    @(negedge clk); #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
